// File: rtl/hazard_ctrl_if.sv
// Pipeline-latch control bundle: hazard inputs from the latches/caches and
// the en/flush controls, halt flag and stall counter returned to the pipeline.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             idex_dREN;
    logic [4:0]       idex_rt;
    logic             exmem_dREN;
    logic             exmem_dWEN;
    logic             exmem_pc_redirect;
    logic             memwb_halt;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             exmem_flush;
    logic             memwb_en;
    logic             memwb_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_count;

    // Pipeline side: supplies hazard inputs, consumes latch controls.
    modport master (
        output ihit, dhit, ifid_rs, ifid_rt, idex_dREN, idex_rt,
               exmem_dREN, exmem_dWEN, exmem_pc_redirect, memwb_halt,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, memwb_flush, halted, stall_count
    );

    // Hazard unit side.
    modport slave (
        input  ihit, dhit, ifid_rs, ifid_rt, idex_dREN, idex_rt,
               exmem_dREN, exmem_dWEN, exmem_pc_redirect, memwb_halt,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, memwb_flush, halted, stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard control for a 5-stage MIPS pipeline: latch en/flush decode, PC enable,
// data-wait / halt tracking and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] stall_cnt;

    logic memop;
    logic lu;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic exmem_en, exmem_flush, memwb_en, memwb_flush;

    assign memop = hz.exmem_dREN | hz.exmem_dWEN;
    assign lu    = hz.idex_dREN && (hz.idex_rt != 5'd0) &&
                   ((hz.idex_rt == hz.ifid_rs) || (hz.idex_rt == hz.ifid_rt));

    // Priority decode; while reset is held the RUN decode is presented.
    always_comb begin
        next_state  = state;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_en    = 1'b0;
        memwb_flush = 1'b0;

        if (nRST && (state == HALT)) begin
            next_state = HALT;
        end else if (hz.memwb_halt) begin
            next_state = HALT;
        end else if (memop && !hz.dhit) begin
            memwb_en    = 1'b1;
            memwb_flush = 1'b1;
            next_state  = MEM_WAIT;
        end else begin
            next_state = RUN;
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            if (hz.exmem_pc_redirect) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (lu) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (!hz.ihit) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    // State register and saturating stall counter.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= RUN;
            stall_cnt <= '0;
        end else begin
            state <= next_state;
            if (!pc_en && (state != HALT) && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign hz.pc_en       = pc_en;
    assign hz.ifid_en     = ifid_en;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_en     = idex_en;
    assign hz.idex_flush  = idex_flush;
    assign hz.exmem_en    = exmem_en;
    assign hz.exmem_flush = exmem_flush;
    assign hz.memwb_en    = memwb_en;
    assign hz.memwb_flush = memwb_flush;
    assign hz.halted      = (state == HALT);
    assign hz.stall_count = stall_cnt;

    // An outstanding data access must keep its request up until dhit.
    a_memop_held : assert property (@(posedge CLK) disable iff (!nRST)
        (state == MEM_WAIT) |-> memop);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic checked against a rule-level reference model.
module tb_hazard_ctrl;
    localparam int unsigned CNT_W = 4;
    localparam int MAXC = (1 << CNT_W) - 1;
    localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2;

    // Control vector order: pc, ifid en/fl, idex en/fl, exmem en/fl, memwb en/fl
    localparam logic [8:0] V_RUN    = 9'b1_10_10_10_10;
    localparam logic [8:0] V_STOP   = 9'b0_00_00_00_00;
    localparam logic [8:0] V_DWAIT  = 9'b0_00_00_00_11;
    localparam logic [8:0] V_REDIR  = 9'b1_11_11_11_10;
    localparam logic [8:0] V_LU     = 9'b0_00_11_10_10;
    localparam logic [8:0] V_IMISS  = 9'b0_11_10_10_10;

    logic CLK = 1'b0;
    logic nRST;
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_state;
    int   m_cnt;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .hz   (bus.slave)
    );

    always #5 CLK = ~CLK;

    logic [8:0] obs;
    assign obs = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
                  bus.exmem_en, bus.exmem_flush, bus.memwb_en, bus.memwb_flush};

    // Which pipeline situation applies this cycle, highest priority first.
    function automatic int situation();
        int  st;
        bit  memop, lu;
        st    = nRST ? m_state : M_RUN;
        memop = bus.exmem_dREN || bus.exmem_dWEN;
        lu    = bus.idex_dREN && bus.idex_rt != 0 &&
                (bus.idex_rt == bus.ifid_rs || bus.idex_rt == bus.ifid_rt);
        if (st == M_HALT)                return 0;
        if (bus.memwb_halt)              return 1;
        if (memop && !bus.dhit)          return 2;
        if (bus.exmem_pc_redirect)       return 3;
        if (lu)                          return 4;
        if (!bus.ihit)                   return 5;
        return 6;
    endfunction

    function automatic logic [8:0] model_ctrl();
        case (situation())
            0, 1:    return V_STOP;
            2:       return V_DWAIT;
            3:       return V_REDIR;
            4:       return V_LU;
            5:       return V_IMISS;
            default: return V_RUN;
        endcase
    endfunction

    task automatic clear_inputs();
        bus.ihit = 1'b1; bus.dhit = 1'b0;
        bus.ifid_rs = 5'd0; bus.ifid_rt = 5'd0;
        bus.idex_dREN = 1'b0; bus.idex_rt = 5'd0;
        bus.exmem_dREN = 1'b0; bus.exmem_dWEN = 1'b0;
        bus.exmem_pc_redirect = 1'b0; bus.memwb_halt = 1'b0;
    endtask

    // Advance one clock edge and update the reference model from the held inputs.
    task automatic tick();
        int sit;
        sit = situation();
        @(posedge CLK);
        if (!nRST) begin
            m_state = M_RUN;
            m_cnt   = 0;
        end else begin
            if (m_state != M_HALT && sit != 3 && sit != 6)
                m_cnt = (m_cnt == MAXC) ? MAXC : m_cnt + 1;
            if (sit <= 1)      m_state = M_HALT;
            else if (sit == 2) m_state = M_WAIT;
            else               m_state = M_RUN;
        end
        #1;
    endtask

    task automatic settle();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        clear_inputs();
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST = 1'b0;
        settle();
        n_checks++;
        if (obs !== V_RUN) begin n_errors++; $display("FAIL reset_decode ctrl got %b want %b", obs, V_RUN); end
        tick();
        nRST = 1'b1;
        settle();
        n_checks++;
        if (bus.halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted got %b want 0", bus.halted); end
        n_checks++;
        if (bus.stall_count !== 4'd0) begin n_errors++; $display("FAIL reset_count got %0d want 0", bus.stall_count); end
    endtask

    task automatic test_run();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            settle();
            n_checks++;
            if (obs !== V_RUN) begin n_errors++; $display("FAIL run_ctrl cyc %0d got %b want %b", i, obs, V_RUN); end
            tick();
        end
        settle();
        n_checks++;
        if (bus.stall_count !== 4'd0) begin n_errors++; $display("FAIL run_count got %0d want 0", bus.stall_count); end
    endtask

    task automatic test_load_use();
        do_reset();
        bus.idex_dREN = 1'b1; bus.idex_rt = 5'd8; bus.ifid_rs = 5'd8;
        settle();
        n_checks++;
        if (obs !== V_LU) begin n_errors++; $display("FAIL lu_ctrl got %b want %b", obs, V_LU); end
        tick();
        clear_inputs();
        settle();
        n_checks++;
        if (obs !== V_RUN) begin n_errors++; $display("FAIL lu_release got %b want %b", obs, V_RUN); end
        n_checks++;
        if (bus.stall_count !== 4'd1) begin n_errors++; $display("FAIL lu_count got %0d want 1", bus.stall_count); end
        tick();
        bus.idex_dREN = 1'b1; bus.idex_rt = 5'd0; bus.ifid_rs = 5'd0; bus.ifid_rt = 5'd0;
        settle();
        n_checks++;
        if (obs !== V_RUN) begin n_errors++; $display("FAIL lu_rt0 got %b want %b", obs, V_RUN); end
        tick();
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        bus.exmem_dREN = 1'b1; bus.dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_checks++;
            if (obs !== V_DWAIT) begin n_errors++; $display("FAIL dwait_ctrl cyc %0d got %b want %b", i, obs, V_DWAIT); end
            tick();
        end
        bus.dhit = 1'b1;
        settle();
        n_checks++;
        if (obs !== V_RUN) begin n_errors++; $display("FAIL dwait_exit got %b want %b", obs, V_RUN); end
        tick();
        clear_inputs();
        settle();
        n_checks++;
        if (bus.stall_count !== 4'd3) begin n_errors++; $display("FAIL dwait_count got %0d want 3", bus.stall_count); end
    endtask

    task automatic test_redirect();
        do_reset();
        bus.exmem_pc_redirect = 1'b1; bus.ihit = 1'b0;
        bus.idex_dREN = 1'b1; bus.idex_rt = 5'd3; bus.ifid_rt = 5'd3;
        settle();
        n_checks++;
        if (obs !== V_REDIR) begin n_errors++; $display("FAIL redir_ctrl got %b want %b", obs, V_REDIR); end
        tick();
        clear_inputs();
        settle();
        n_checks++;
        if (bus.stall_count !== 4'd0) begin n_errors++; $display("FAIL redir_count got %0d want 0", bus.stall_count); end
    endtask

    task automatic test_halt();
        do_reset();
        bus.memwb_halt = 1'b1;
        settle();
        n_checks++;
        if (obs !== V_STOP) begin n_errors++; $display("FAIL halt_enter got %b want %b", obs, V_STOP); end
        tick();
        bus.memwb_halt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.ihit = 1'($urandom_range(0, 1));
            bus.dhit = 1'($urandom_range(0, 1));
            bus.exmem_pc_redirect = 1'($urandom_range(0, 1));
            settle();
            n_checks++;
            if (obs !== V_STOP || bus.halted !== 1'b1)
                begin n_errors++; $display("FAIL halt_hold cyc %0d got %b/%b want %b/1", i, obs, bus.halted, V_STOP); end
            tick();
        end
        settle();
        n_checks++;
        if (bus.stall_count !== 4'd1) begin n_errors++; $display("FAIL halt_count got %0d want 1", bus.stall_count); end
        do_reset();
        settle();
        n_checks++;
        if (bus.halted !== 1'b0 || bus.stall_count !== 4'd0)
            begin n_errors++; $display("FAIL halt_reset got %b/%0d want 0/0", bus.halted, bus.stall_count); end
    endtask

    task automatic test_saturate();
        do_reset();
        bus.idex_dREN = 1'b1; bus.idex_rt = 5'd5; bus.ifid_rs = 5'd5;
        for (int i = 0; i < 15; i++) tick();
        settle();
        n_checks++;
        if (bus.stall_count !== 4'd15) begin n_errors++; $display("FAIL sat_reach got %0d want 15", bus.stall_count); end
        tick();
        settle();
        n_checks++;
        if (bus.stall_count !== 4'd15) begin n_errors++; $display("FAIL sat_hold got %0d want 15", bus.stall_count); end
        clear_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.ihit       = ($urandom_range(0, 99) < 80);
            bus.dhit       = ($urandom_range(0, 99) < 50);
            bus.ifid_rs    = 5'($urandom_range(0, 3));
            bus.ifid_rt    = 5'($urandom_range(0, 3));
            bus.idex_dREN  = ($urandom_range(0, 99) < 40);
            bus.idex_rt    = 5'($urandom_range(0, 3));
            bus.exmem_dREN = ($urandom_range(0, 99) < 20);
            bus.exmem_dWEN = ($urandom_range(0, 99) < 15);
            if (m_state == M_WAIT && !bus.exmem_dWEN) bus.exmem_dREN = 1'b1;
            bus.exmem_pc_redirect = ($urandom_range(0, 99) < 15);
            bus.memwb_halt = ($urandom_range(0, 99) < 2);
            nRST = !(m_state == M_HALT && $urandom_range(0, 99) < 15);
            settle();
            n_checks++;
            if (obs !== model_ctrl()) begin n_errors++; $display("FAIL rand_ctrl cyc %0d got %b want %b", i, obs, model_ctrl()); end
            n_checks++;
            if (bus.halted !== (m_state == M_HALT) || 32'(bus.stall_count) !== m_cnt)
                begin n_errors++; $display("FAIL rand_state cyc %0d got %b/%0d want %b/%0d", i, bus.halted, bus.stall_count, m_state == M_HALT, m_cnt); end
            tick();
        end
        nRST = 1'b1;
        clear_inputs();
    endtask

    initial begin
        m_state = M_RUN;
        m_cnt   = 0;
        clear_inputs();
        nRST = 1'b0;
        #1;
        test_reset();
        test_run();
        test_load_use();
        test_mem_wait();
        test_redirect();
        test_halt();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Control end of the pipeline latches. It consumes the ID/EX, EX/MEM and MEM/WB latch outputs plus cache hit strobes.
- It drives every latch's en/flush pair and the PC enable for the 5-stage MIPS pipeline.
- It resolves load-use stalls, taken-branch/jump flushes, data-memory wait, I-fetch miss bubbles and halt.
- It also maintains a saturating stall-cycle counter for performance reporting.

Parameters:
- CNT_W, 32, width of stall_count.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  synchronous active-low reset.
- ihit  in  1  instruction fetch completed this cycle.
- dhit  in  1  data access completed this cycle.
- ifid_rs  in  5  rs field of instruction in IF/ID.
- ifid_rt  in  5  rt field of instruction in IF/ID.
- idex_dREN  in  1  ID/EX dREN_o (load in EX).
- idex_rt  in  5  ID/EX rt_o.
- exmem_dREN  in  1  EX/MEM data read request.
- exmem_dWEN  in  1  EX/MEM data write request.
- exmem_pc_redirect  in  1  taken branch, jump, jr or jal resolved in MEM.
- memwb_halt  in  1  MEM/WB halt_o.
- pc_en  out  1  PC register update enable.
- ifid_en  out  1  IF/ID latch enable.
- ifid_flush  out  1  IF/ID latch flush.
- idex_en  out  1  ID/EX latch enable.
- idex_flush  out  1  ID/EX latch flush.
- exmem_en  out  1  EX/MEM latch enable.
- exmem_flush  out  1  EX/MEM latch flush.
- memwb_en  out  1  MEM/WB latch enable.
- memwb_flush  out  1  MEM/WB latch flush.
- halted  out  1  pipeline halted.
- stall_count  out  CNT_W  cycles with pc_en=0 while not halted.

Behaviour:
- Reset: on a rising CLK with nRST=0, state becomes RUN, stall_count becomes 0 and halted becomes 0.
- Outputs are decoded combinationally from registered state and current inputs.
- Flush has priority over en inside each latch, so flush with en=0 is never driven.
- States: RUN, MEM_WAIT, HALT.
- Definitions: memop = exmem_dREN|exmem_dWEN. lu = idex_dREN & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt).
- RUN / MEM_WAIT decode, first match wins:
  1. memwb_halt: all en=0, all flush=0. Next state is HALT.
  2. memop & !dhit: pc_en=ifid_en=idex_en=exmem_en=0, memwb_en=1, memwb_flush=1 (bubble into WB). Next state is MEM_WAIT.
  3. exmem_pc_redirect (dhit or no memop): all en=1, ifid_flush=idex_flush=exmem_flush=1, pc_en=1 (PC loads target). This overrides lu and ihit=0. Next state is RUN.
  4. lu: pc_en=0, ifid_en=0, idex_flush=1 (one bubble), remaining en=1. Next state is RUN.
  5. !ihit: pc_en=0, ifid_flush=1, remaining en=1. Next state is RUN.
  6. Otherwise: all en=1, all flush=0. Next state is RUN.
- MEM_WAIT is entered only via rule 2 and is left on the cycle dhit=1. That exit cycle decodes rules 3-6 normally.
- ihit is ignored while in MEM_WAIT (the data side owns the cache port). The fetch is retried after exit.
- If memop drops without dhit while in MEM_WAIT, the block returns to RUN. This is a protocol violation, flagged by an assertion.
- HALT: all en=0, all flush=0, halted=1. The block leaves HALT only on reset; it ignores all other inputs.
- Load-use with rt=0 is never a hazard.
- lu and !ihit in the same cycle: rule 4 applies. PC and IF/ID hold, so the fetch is retried.
- stall_count increments on each CLK edge where pc_en=0 and state!=HALT. It saturates at all-ones with no wrap.
- Reset mid-MEM_WAIT or mid-HALT returns to RUN on that edge. During the nRST=0 cycle, outputs follow RUN decode.
- Latency: every decision takes effect in the same cycle as its inputs. The state register adds a 1-cycle memory of an outstanding data access.

Test Plan:
- Reset, then ihit=1 and no hazards for 10 cycles -> all en=1, flush=0, stall_count=0, halted=0.
- idex_dREN=1, idex_rt=8, ifid_rs=8 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle only. stall_count=1. Repeat with idex_rt=0 -> no stall.
- exmem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> state MEM_WAIT, pc_en=exmem_en=0, memwb_flush=1 for 3 cycles; RUN decode on the 4th. stall_count=3.
- exmem_pc_redirect=1 with lu=1 and ihit=0 -> ifid_flush=idex_flush=exmem_flush=1, pc_en=1, no stall counted.
- memwb_halt=1 -> halted=1 next cycle; all en=0 for 20 cycles despite ihit/dhit toggling. stall_count frozen. nRST=0 for one edge -> halted=0, stall_count=0.
- Force stall_count to all-ones via 2^CNT_W-1 stalls (CNT_W=4: 15 load-use stalls), then one more stall -> stall_count stays 15.
